// File: rtl/nios_mem_arbiter_pkg.sv
// Shared types for the nios_2 unified-memory arbiter: FSM encoding, grant
// identifiers and the data word returned on an aborted access.
package nios_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;
endpackage

// File: rtl/nios_mem_arbiter_if.sv
// Bundle of the core-side (fetch + data) and memory-side signals of the arbiter.
interface nios_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [7:0]        if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              dm_rd;
  logic              dm_wr;
  logic [31:0]       dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              cpu_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              err;

  // Arbiter view.
  modport slave (
    input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_valid, dm_rdata, dm_valid, cpu_stall,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );

  // Core + memory view.
  modport master (
    output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_valid, dm_rdata, dm_valid, cpu_stall,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/nios_mem_arbiter_rr.sv
// Two-way fetch/data selector: fixed data priority or alternation on a tie,
// remembering the last granted port.
module nios_arb_rr
  import nios_arb_pkg::*;
#(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   req_i,
  input  logic   req_d,
  input  logic   take,
  output grant_e gnt,
  output logic   any
);
  grant_e last_q;

  assign any = req_i | req_d;

  always_comb begin
    gnt = GNT_I;
    if (req_d && !req_i) gnt = GNT_D;
    else if (req_d && req_i) begin
      if (DATA_PRIORITY || last_q == GNT_I) gnt = GNT_D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              last_q <= GNT_I;
    else if (take && any) last_q <= gnt;
  end
endmodule

// File: rtl/nios_mem_arbiter.sv
// Shares one single-ported memory between the nios_2 fetch and data ports:
// grant, issue, wait for ack (with timeout), return data, and stall the core.
module nios_mem_arbiter
  import nios_arb_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 32,
  parameter bit DATA_PRIORITY = 1'b1,
  parameter int TIMEOUT       = 15
) (
  input logic               clk,
  input logic               rst,
  nios_mem_arbiter_if.slave bus
);
  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [7:0]        wait_q;
  logic              req_i, req_d, any, take, done, abort;
  grant_e            gnt;
  logic              unused_addr;

  // A port whose valid pulse is out this cycle is finished, not re-requesting.
  assign req_i = bus.if_req & ~bus.if_valid;
  assign req_d = (bus.dm_rd | bus.dm_wr) & ~bus.dm_valid;
  assign take  = (state_q == IDLE) & any;

  assign bus.cpu_stall = req_i | req_d;
  assign bus.mem_req   = (state_q != IDLE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_wdata = wdata_q;
  assign unused_addr   = ^bus.dm_addr[31:ADDR_W];

  nios_arb_rr #(.DATA_PRIORITY(DATA_PRIORITY)) u_rr (
    .clk  (clk),
    .rst  (rst),
    .req_i(req_i),
    .req_d(req_d),
    .take (take),
    .gnt  (gnt),
    .any  (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: if (any) state_d = (gnt == GNT_D) ? BUSY_D : BUSY_I;
      BUSY_I, BUSY_D: begin
        if (bus.mem_ack)                      done  = 1'b1;
        else if (wait_q == 8'(TIMEOUT - 1))   abort = 1'b1;
        if (done || abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      wait_q       <= '0;
      bus.if_rdata <= '0;
      bus.dm_rdata <= '0;
      bus.if_valid <= 1'b0;
      bus.dm_valid <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.if_valid <= 1'b0;
      bus.dm_valid <= 1'b0;
      bus.err      <= 1'b0;
      if (take) begin
        wait_q <= '0;
        if (gnt == GNT_D) begin
          addr_q  <= bus.dm_addr[ADDR_W-1:0];
          wdata_q <= bus.dm_wdata;
          we_q    <= bus.dm_wr;
          bus.err <= bus.dm_rd & bus.dm_wr;
        end else begin
          addr_q <= ADDR_W'(bus.if_addr);
          we_q   <= 1'b0;
        end
      end else if (state_q != IDLE) begin
        wait_q <= wait_q + 8'd1;
        if (done || abort) begin
          bus.err <= abort;
          if (state_q == BUSY_I) begin
            bus.if_valid <= 1'b1;
            bus.if_rdata <= done ? bus.mem_rdata : DATA_W'(TIMEOUT_DATA);
          end else begin
            bus.dm_valid <= 1'b1;
            if (abort)      bus.dm_rdata <= DATA_W'(TIMEOUT_DATA);
            else if (!we_q) bus.dm_rdata <= bus.mem_rdata;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_nios_mem_arbiter.sv
// Bench for nios_mem_arbiter: directed vector table, multi-cycle corner
// sequences, round-robin on a second instance, and randomized traffic.
module tb_nios_mem_arbiter;
  import nios_arb_pkg::*;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nios_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  nios_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_rr ();

  nios_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DATA_PRIORITY(1'b1), .TIMEOUT(TIMEOUT))
    u_dut (.clk(clk), .rst(rst), .bus(bus));
  nios_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DATA_PRIORITY(1'b0), .TIMEOUT(TIMEOUT))
    u_rr (.clk(clk), .rst(rst), .bus(bus_rr));

  // Memory model: ack after ack_wait busy cycles, 256-word array.
  logic [31:0] mem [0:255];
  int   busy_cnt  = 0;
  int   ack_wait  = 0;
  logic force_ack = 1'b0;
  logic mem_init  = 1'b1;

  function automatic logic [31:0] init_val(input int i);
    return (i == 8) ? 32'h12345678 : 32'h10000000 + 32'(i);
  endfunction

  assign bus.mem_ack      = force_ack | (bus.mem_req & (busy_cnt == ack_wait));
  assign bus.mem_rdata    = mem[bus.mem_addr[7:0]];
  assign bus_rr.mem_ack   = bus_rr.mem_req;
  assign bus_rr.mem_rdata = {16'h0, bus_rr.mem_addr};

  always @(posedge clk) begin
    busy_cnt <= bus.mem_req ? busy_cnt + 1 : 0;
    if (mem_init) for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    else if (bus.mem_req && bus.mem_we && bus.mem_ack) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          fetch;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [15:0] exp_maddr;
    bit          exp_we;
    logic [31:0] exp_rdata;
    bit          exp_err_gnt;
    bit          exp_err_done;
  } vec_t;

  vec_t vecs [10];

  task automatic run_vec(input vec_t v, input int idx);
    int nbusy;
    nbusy = (v.waits + 1 < TIMEOUT) ? v.waits + 1 : TIMEOUT;
    @(negedge clk);
    ack_wait = v.waits;
    if (v.fetch) begin
      bus.if_req = 1'b1; bus.if_addr = v.addr[7:0];
    end else begin
      bus.dm_rd = v.rd; bus.dm_wr = v.wr; bus.dm_addr = v.addr; bus.dm_wdata = v.wdata;
    end
    #1;
    chk($sformatf("v%0d_stall_req", idx), 64'(bus.cpu_stall), 64'd1);
    chk($sformatf("v%0d_req_n", idx), 64'(bus.mem_req), 64'd0);
    for (int b = 0; b < nbusy; b++) begin
      @(negedge clk);
      chk($sformatf("v%0d_mem_req_b%0d", idx, b), 64'(bus.mem_req), 64'd1);
      chk($sformatf("v%0d_mem_addr_b%0d", idx, b), 64'(bus.mem_addr), 64'(v.exp_maddr));
      chk($sformatf("v%0d_mem_we_b%0d", idx, b), 64'(bus.mem_we), 64'(v.exp_we));
      if (v.wr) chk($sformatf("v%0d_wdata_b%0d", idx, b), 64'(bus.mem_wdata), 64'(v.wdata));
      if (b == 0) chk($sformatf("v%0d_err_gnt", idx), 64'(bus.err), 64'(v.exp_err_gnt));
      chk($sformatf("v%0d_stall_b%0d", idx, b), 64'(bus.cpu_stall), 64'd1);
    end
    @(negedge clk);
    if (v.fetch) begin
      chk($sformatf("v%0d_if_valid", idx), 64'(bus.if_valid), 64'd1);
      chk($sformatf("v%0d_if_rdata", idx), 64'(bus.if_rdata), 64'(v.exp_rdata));
    end else begin
      chk($sformatf("v%0d_dm_valid", idx), 64'(bus.dm_valid), 64'd1);
      chk($sformatf("v%0d_dm_rdata", idx), 64'(bus.dm_rdata), 64'(v.exp_rdata));
    end
    chk($sformatf("v%0d_err_done", idx), 64'(bus.err), 64'(v.exp_err_done));
    chk($sformatf("v%0d_stall_done", idx), 64'(bus.cpu_stall), 64'd0);
    chk($sformatf("v%0d_req_done", idx), 64'(bus.mem_req), 64'd0);
    bus.if_req = 1'b0; bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_pulse", idx), 64'(bus.if_valid | bus.dm_valid), 64'd0);
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    summary();
    $finish;
  end

  initial begin
    logic [31:0] shadow [0:255];
    logic [31:0] last_dm, da, dwd;
    logic [7:0]  ia;
    bit          ip, dp, dwr, done_i, done_d, last_port;
    int          iage, dage, cnt;

    bus.if_req = 0; bus.if_addr = 0; bus.dm_rd = 0; bus.dm_wr = 0; bus.dm_addr = 0; bus.dm_wdata = 0;
    bus_rr.if_req = 0; bus_rr.if_addr = 0; bus_rr.dm_rd = 0; bus_rr.dm_wr = 0;
    bus_rr.dm_addr = 0; bus_rr.dm_wdata = 0;

    //          fetch rd wr addr           wdata          waits maddr    we  rdata          eg ed
    vecs[0] = '{1'b1, 0, 0, 32'h0000_0008, 32'h0,         0,    16'h0008, 0, 32'h12345678, 0, 0};
    vecs[1] = '{1'b0, 1, 0, 32'h0000_0010, 32'h0,         1,    16'h0010, 0, 32'h10000010, 0, 0};
    vecs[2] = '{1'b0, 0, 1, 32'h0000_0020, 32'hCAFEF00D,  2,    16'h0020, 1, 32'h10000010, 0, 0};
    vecs[3] = '{1'b0, 1, 0, 32'h0000_0020, 32'h0,         0,    16'h0020, 0, 32'hCAFEF00D, 0, 0};
    vecs[4] = '{1'b0, 1, 0, 32'h0001_0044, 32'h0,         0,    16'h0044, 0, 32'h10000044, 0, 0};
    vecs[5] = '{1'b0, 1, 1, 32'h0000_0030, 32'h11112222,  0,    16'h0030, 1, 32'h10000044, 1, 0};
    vecs[6] = '{1'b0, 1, 0, 32'h0000_0030, 32'h0,         3,    16'h0030, 0, 32'h11112222, 0, 0};
    vecs[7] = '{1'b1, 0, 0, 32'h0000_00FF, 32'h0,         14,   16'h00FF, 0, 32'h100000FF, 0, 0};
    vecs[8] = '{1'b0, 1, 0, 32'h0000_0040, 32'h0,         1000, 16'h0040, 0, 32'hDEADBEEF, 0, 1};
    vecs[9] = '{1'b1, 0, 0, 32'h0000_0050, 32'h0,         1000, 16'h0050, 0, 32'hDEADBEEF, 0, 1};

    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_if_valid", 64'(bus.if_valid), 64'd0);
    chk("rst_dm_valid", 64'(bus.dm_valid), 64'd0);
    chk("rst_if_rdata", 64'(bus.if_rdata), 64'd0);
    chk("rst_dm_rdata", 64'(bus.dm_rdata), 64'd0);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_stall", 64'(bus.cpu_stall), 64'd0);
    @(negedge clk);
    rst = 1'b0; mem_init = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Ack arriving after the timeout abort, with no access in flight.
    @(negedge clk);
    force_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("late_ack_req_%0d", c), 64'(bus.mem_req), 64'd0);
      chk($sformatf("late_ack_valid_%0d", c), 64'(bus.if_valid | bus.dm_valid), 64'd0);
      chk($sformatf("late_ack_err_%0d", c), 64'(bus.err), 64'd0);
      chk($sformatf("late_ack_rdata_%0d", c), 64'(bus.if_rdata), 64'h0DEADBEEF);
    end
    force_ack = 1'b0;

    // Fetch and data together: data first (2 waits), then fetch (0 waits).
    @(negedge clk);
    ack_wait = 2;
    bus.if_req = 1'b1; bus.if_addr = 8'h04; bus.dm_rd = 1'b1; bus.dm_addr = 32'h100;
    @(negedge clk);
    chk("prio_first_addr", 64'(bus.mem_addr), 64'h0100);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("prio_dm_valid", 64'(bus.dm_valid), 64'd1);
    chk("prio_if_not_yet", 64'(bus.if_valid), 64'd0);
    chk("prio_dm_rdata", 64'(bus.dm_rdata), 64'h10000000);
    chk("prio_stall_fetch", 64'(bus.cpu_stall), 64'd1);
    bus.dm_rd = 1'b0; ack_wait = 0;
    @(negedge clk);
    chk("prio_second_req", 64'(bus.mem_req), 64'd1);
    chk("prio_second_addr", 64'(bus.mem_addr), 64'h0004);
    @(negedge clk);
    chk("prio_if_valid", 64'(bus.if_valid), 64'd1);
    chk("prio_if_rdata", 64'(bus.if_rdata), 64'h10000004);
    chk("prio_stall_low", 64'(bus.cpu_stall), 64'd0);
    bus.if_req = 1'b0;

    // Reset in the middle of a data access with waits pending.
    @(negedge clk);
    ack_wait = 5; bus.dm_rd = 1'b1; bus.dm_addr = 32'h12;
    @(negedge clk); @(negedge clk);
    chk("rmid_busy", 64'(bus.mem_req), 64'd1);
    rst = 1'b1;
    #1;
    chk("rmid_req_drop", 64'(bus.mem_req), 64'd0);
    chk("rmid_valid", 64'(bus.dm_valid), 64'd0);
    bus.dm_rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rpost_req", 64'(bus.mem_req), 64'd0);
    chk("rpost_valid", 64'(bus.if_valid | bus.dm_valid), 64'd0);
    chk("rpost_err", 64'(bus.err), 64'd0);
    chk("rpost_addr", 64'(bus.mem_addr), 64'd0);
    chk("rpost_dm_rdata", 64'(bus.dm_rdata), 64'd0);
    chk("rpost_if_rdata", 64'(bus.if_rdata), 64'd0);
    run_vec(vecs[0], 20);

    // Round-robin instance, both ports held: D first, then strict alternation.
    @(negedge clk);
    bus_rr.if_req = 1'b1; bus_rr.if_addr = 8'h11; bus_rr.dm_rd = 1'b1; bus_rr.dm_addr = 32'h22;
    cnt = 0; last_port = 1'b0;
    for (int c = 0; c < 40 && cnt < 8; c++) begin
      @(negedge clk);
      if (bus_rr.if_valid || bus_rr.dm_valid) begin
        chk($sformatf("rr_onehot_%0d", cnt), 64'(bus_rr.if_valid & bus_rr.dm_valid), 64'd0);
        if (cnt == 0) chk("rr_first", 64'(bus_rr.dm_valid), 64'd1);
        else chk($sformatf("rr_alt_%0d", cnt), 64'(bus_rr.dm_valid), 64'(!last_port));
        if (bus_rr.dm_valid) chk($sformatf("rr_ddata_%0d", cnt), 64'(bus_rr.dm_rdata), 64'h22);
        else chk($sformatf("rr_idata_%0d", cnt), 64'(bus_rr.if_rdata), 64'h11);
        last_port = bus_rr.dm_valid;
        cnt++;
      end
    end
    chk("rr_count", 64'(cnt), 64'd8);
    bus_rr.if_req = 1'b0; bus_rr.dm_rd = 1'b0;

    // Randomized traffic: fetch in 0x00-0x1F, data in 0x20-0x3F (random upper bits).
    @(negedge clk);
    mem_init = 1'b1;
    @(negedge clk);
    mem_init = 1'b0;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    last_dm = 32'h0; ip = 0; dp = 0; iage = 0; dage = 0; ia = 0; da = 0; dwd = 0; dwr = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      done_i = 0; done_d = 0;
      chk("rnd_err", 64'(bus.err), 64'd0);
      if (bus.mem_req)
        chk("rnd_maddr", 64'((ip && bus.mem_addr == 16'(ia)) || (dp && bus.mem_addr == da[15:0])), 64'd1);
      if (bus.if_valid) begin
        chk("rnd_if_pend", 64'(ip), 64'd1);
        chk("rnd_if_data", 64'(bus.if_rdata), 64'(shadow[ia]));
        chk("rnd_if_lat", 64'(iage <= 40), 64'd1);
        ip = 0; bus.if_req = 1'b0; done_i = 1;
      end
      if (bus.dm_valid) begin
        chk("rnd_dm_pend", 64'(dp), 64'd1);
        if (dwr) begin
          chk("rnd_wr_keep", 64'(bus.dm_rdata), 64'(last_dm));
          shadow[da[7:0]] = dwd;
        end else begin
          chk("rnd_rd_data", 64'(bus.dm_rdata), 64'(shadow[da[7:0]]));
          last_dm = shadow[da[7:0]];
        end
        chk("rnd_dm_lat", 64'(dage <= 40), 64'd1);
        dp = 0; bus.dm_rd = 1'b0; bus.dm_wr = 1'b0; done_d = 1;
      end
      if (ip && ++iage == 60) begin
        n_cmp++; n_bad++;
        $display("FAIL rnd_if_hang: pending %0d cycles, limit 40", iage);
        ip = 0; bus.if_req = 1'b0;
      end
      if (dp && ++dage == 60) begin
        n_cmp++; n_bad++;
        $display("FAIL rnd_dm_hang: pending %0d cycles, limit 40", dage);
        dp = 0; bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
      end
      if (!ip && !done_i && $urandom_range(0, 2) == 0) begin
        ia = 8'($urandom_range(0, 31));
        bus.if_addr = ia; bus.if_req = 1'b1; ip = 1; iage = 0;
      end
      if (!dp && !done_d && $urandom_range(0, 2) == 0) begin
        da  = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(32, 63));
        dwr = 1'($urandom_range(0, 1));
        dwd = $urandom();
        bus.dm_addr = da; bus.dm_wdata = dwd; bus.dm_rd = !dwr; bus.dm_wr = dwr;
        dp = 1; dage = 0;
      end
      if (!bus.mem_req) ack_wait = $urandom_range(0, 3);
    end
    bus.if_req = 1'b0; bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
    repeat (20) @(negedge clk);

    summary();
    $finish;
  end
endmodule
